// File: rtl/hesap_pkg.sv
// Shared calculator datapath definitions: FSM states, default width and
// the all-ones quotient returned on divide-by-zero.
package hesap_pkg;

    typedef enum logic [1:0] {
        BOS   = 2'd0,
        HESAP = 2'd1,
        BITTI = 2'd2
    } durum_t;

    localparam int unsigned VARSAYILAN_GENISLIK = 32;
    localparam int unsigned AZAMI_GENISLIK      = 64;

    // Sliced down to WIDTH by the user.
    localparam logic [AZAMI_GENISLIK-1:0] TUM_BIRLER = '1;

endpackage

// File: rtl/bolme_adim.sv
// One restoring shift-subtract step: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, report the quotient bit.
module bolme_adim
    import hesap_pkg::*;
#(
    parameter int unsigned WIDTH = VARSAYILAN_GENISLIK
) (
    input  logic [WIDTH:0]   i_kalan,
    input  logic             i_bolunen_msb,
    input  logic [WIDTH-1:0] i_bolen,
    output logic [WIDTH:0]   o_kalan,
    output logic             o_bit
);

    logic [WIDTH+1:0] w_kaydir;
    logic [WIDTH:0]   w_fark;

    // Trial subtraction; the difference only fits when the divisor fits.
    always_comb begin
        w_kaydir = {i_kalan, i_bolunen_msb};
        o_bit    = (w_kaydir >= {2'b00, i_bolen});
        w_fark   = w_kaydir[WIDTH:0] - {1'b0, i_bolen};
        o_kalan  = o_bit ? w_fark : w_kaydir[WIDTH:0];
    end

endmodule

// File: rtl/bolme.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with
// busy/done handshake and divide-by-zero flag.
module bolme
    import hesap_pkg::*;
#(
    parameter int unsigned WIDTH = VARSAYILAN_GENISLIK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             basla,
    input  logic [WIDTH-1:0] bolunen,
    input  logic [WIDTH-1:0] bolen,
    output logic [WIDTH-1:0] bolum,
    output logic [WIDTH-1:0] kalan,
    output logic             mesgul,
    output logic             hazir,
    output logic             sifira_bolme
);

    localparam int unsigned SAYAC_W = $clog2(WIDTH + 1);

    durum_t             r_durum;
    logic [SAYAC_W-1:0] r_sayac;
    logic [WIDTH:0]     r_kalan_ara;
    // Dividend shifts out at the top while quotient bits shift in at the bottom.
    logic [WIDTH-1:0]   r_bolunen;
    logic [WIDTH-1:0]   r_bolen;
    logic [WIDTH-1:0]   r_bolum;
    logic [WIDTH-1:0]   r_kalan;
    logic               r_mesgul;
    logic               r_hazir;
    logic               r_sifir;

    logic [WIDTH:0]     w_sonraki;
    logic               w_bit;

    bolme_adim #(
        .WIDTH (WIDTH)
    ) u_adim (
        .i_kalan       (r_kalan_ara),
        .i_bolunen_msb (r_bolunen[WIDTH-1]),
        .i_bolen       (r_bolen),
        .o_kalan       (w_sonraki),
        .o_bit         (w_bit)
    );

    // Control FSM plus datapath registers; all outputs are registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_durum     <= BOS;
            r_sayac     <= '0;
            r_kalan_ara <= '0;
            r_bolunen   <= '0;
            r_bolen     <= '0;
            r_bolum     <= '0;
            r_kalan     <= '0;
            r_mesgul    <= 1'b0;
            r_hazir     <= 1'b0;
            r_sifir     <= 1'b0;
        end else begin
            unique case (r_durum)
                BOS: begin
                    r_hazir <= 1'b0;
                    if (basla) begin
                        if (bolen != '0) begin
                            r_bolunen   <= bolunen;
                            r_bolen     <= bolen;
                            r_kalan_ara <= '0;
                            r_sayac     <= SAYAC_W'(WIDTH);
                            r_mesgul    <= 1'b1;
                            r_sifir     <= 1'b0;
                            r_durum     <= HESAP;
                        end else begin
                            // Divide-by-zero skips iteration and reports at once.
                            r_bolum <= TUM_BIRLER[WIDTH-1:0];
                            r_kalan <= bolunen;
                            r_sifir <= 1'b1;
                            r_hazir <= 1'b1;
                            r_durum <= BITTI;
                        end
                    end
                end
                HESAP: begin
                    r_kalan_ara <= w_sonraki;
                    r_bolunen   <= {r_bolunen[WIDTH-2:0], w_bit};
                    r_sayac     <= r_sayac - SAYAC_W'(1);
                    if (r_sayac == SAYAC_W'(1)) begin
                        r_bolum  <= {r_bolunen[WIDTH-2:0], w_bit};
                        r_kalan  <= w_sonraki[WIDTH-1:0];
                        r_mesgul <= 1'b0;
                        r_hazir  <= 1'b1;
                        r_durum  <= BITTI;
                    end
                end
                BITTI: begin
                    r_hazir <= 1'b0;
                    r_durum <= BOS;
                end
                default: begin
                    r_durum <= BOS;
                end
            endcase
        end
    end

    assign bolum        = r_bolum;
    assign kalan        = r_kalan;
    assign mesgul       = r_mesgul;
    assign hazir        = r_hazir;
    assign sifira_bolme = r_sifir;

endmodule

// File: tb/tb_bolme.sv
// Directed bench for the bolme divider: reset values, hand-computed vectors,
// divide-by-zero, abort by reset, and random operands against / and %.
module tb_bolme;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         basla;
    logic [W-1:0] bolunen;
    logic [W-1:0] bolen;
    logic [W-1:0] bolum;
    logic [W-1:0] kalan;
    logic         mesgul;
    logic         hazir;
    logic         sifira_bolme;

    int n_top  = 0;
    int n_gec  = 0;
    int n_hata = 0;

    always #5 clk = ~clk;

    bolme #(
        .WIDTH (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .basla        (basla),
        .bolunen      (bolunen),
        .bolen        (bolen),
        .bolum        (bolum),
        .kalan        (kalan),
        .mesgul       (mesgul),
        .hazir        (hazir),
        .sifira_bolme (sifira_bolme)
    );

    task automatic chk(input string ad, input logic [63:0] gozlenen, input logic [63:0] beklenen);
        n_top = n_top + 1;
        assert (gozlenen === beklenen) n_gec = n_gec + 1;
        else begin
            n_hata = n_hata + 1;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", ad, gozlenen, beklenen);
        end
    endtask

    // Start a division, follow it to hazir, check timing, handshake and result.
    task automatic bolme_yap(input string ad, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] q_bek, input logic [W-1:0] r_bek,
                             input logic z_bek);
        int lat;
        bit mesgul_dogru;
        logic mesgul_bek;
        mesgul_bek = (b != '0);
        @(negedge clk);
        basla   = 1'b1;
        bolunen = a;
        bolen   = b;
        @(negedge clk);
        basla   = 1'b0;
        bolunen = $urandom;
        bolen   = $urandom;
        lat = 1;
        mesgul_dogru = 1'b1;
        chk({ad, "/sifir_bayrak_erken"}, 64'(sifira_bolme), 64'(z_bek));
        while (hazir !== 1'b1 && lat < 100) begin
            if (mesgul !== mesgul_bek) mesgul_dogru = 1'b0;
            @(negedge clk);
            lat = lat + 1;
        end
        chk({ad, "/gecikme"}, 64'(lat), z_bek ? 64'd1 : 64'(W + 1));
        chk({ad, "/mesgul_desen"}, 64'(mesgul_dogru), 64'd1);
        chk({ad, "/mesgul_hazirda"}, 64'(mesgul), 64'd0);
        chk({ad, "/bolum"}, 64'(bolum), 64'(q_bek));
        chk({ad, "/kalan"}, 64'(kalan), 64'(r_bek));
        chk({ad, "/sifira_bolme"}, 64'(sifira_bolme), 64'(z_bek));
        @(negedge clk);
        chk({ad, "/hazir_tek_cevrim"}, 64'(hazir), 64'd0);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        bit           hazir_goruldu;

        rst     = 1'b0;
        basla   = 1'b0;
        bolunen = '0;
        bolen   = '0;
        #1;
        chk("reset/bolum", 64'(bolum), 64'd0);
        chk("reset/kalan", 64'(kalan), 64'd0);
        chk("reset/mesgul", 64'(mesgul), 64'd0);
        chk("reset/hazir", 64'(hazir), 64'd0);
        chk("reset/sifira_bolme", 64'(sifira_bolme), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        bolme_yap("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        bolme_yap("max/1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
        bolme_yap("max/max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        bolme_yap("5/9", 32'd5, 32'd9, 32'd0, 32'd5, 1'b0);
        bolme_yap("0/3", 32'd0, 32'd3, 32'd0, 32'd0, 1'b0);
        bolme_yap("1234/0", 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1);
        bolme_yap("10/3", 32'd10, 32'd3, 32'd3, 32'd1, 1'b0);
        bolme_yap("max/2", 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1, 1'b0);

        // Abort: a start during iteration is ignored, reset kills the division.
        @(negedge clk);
        basla   = 1'b1;
        bolunen = 32'd1000;
        bolen   = 32'd10;
        @(negedge clk);
        basla = 1'b0;
        repeat (8) @(negedge clk);
        basla   = 1'b1;
        bolunen = 32'd50;
        bolen   = 32'd5;
        @(negedge clk);
        basla = 1'b0;
        chk("iptal/mesgul_surer", 64'(mesgul), 64'd1);
        hazir_goruldu = 1'b0;
        repeat (9) begin
            @(negedge clk);
            if (hazir === 1'b1) hazir_goruldu = 1'b1;
        end
        #2 rst = 1'b0;
        #1;
        chk("iptal/bolum", 64'(bolum), 64'd0);
        chk("iptal/kalan", 64'(kalan), 64'd0);
        chk("iptal/mesgul", 64'(mesgul), 64'd0);
        chk("iptal/hazir", 64'(hazir), 64'd0);
        chk("iptal/sifira_bolme", 64'(sifira_bolme), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (hazir === 1'b1) hazir_goruldu = 1'b1;
        end
        chk("iptal/hazir_yok", 64'(hazir_goruldu), 64'd0);
        bolme_yap("50/5", 32'd50, 32'd5, 32'd10, 32'd0, 1'b0);

        // Random operands; smaller divisors mixed in to exercise large quotients.
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 2 == 1) rb = rb >> $urandom_range(0, 31);
            if (rb == '0) rb = 32'd1;
            bolme_yap("rastgele", ra, rb, ra / rb, ra % rb, 1'b0);
        end

        $display("%0d/%0d checks passed", n_gec, n_top);
        $finish;
    end

endmodule

// File: doc/bolme.md
# bolme

Sequential unsigned integer divider, the inverse of the team's shift-add multiplier (`carpma`). It computes quotient and remainder of two WIDTH-bit operands with a restoring shift-subtract algorithm, one quotient bit per clock. It sits beside the multiplier in the calculator datapath and uses the same `basla` start convention. It adds a busy/done handshake and divide-by-zero flagging.

## Interface
- `WIDTH`, 32, operand width in bits; legal values 2..64.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `basla`  in  1  start request, sampled on the rising edge.
- `bolunen`  in  WIDTH  dividend, captured on the accepted start edge.
- `bolen`  in  WIDTH  divisor, captured on the accepted start edge.
- `bolum`  out  WIDTH  quotient, registered.
- `kalan`  out  WIDTH  remainder, registered.
- `mesgul`  out  1  high while a division is in progress.
- `hazir`  out  1  one-cycle pulse when `bolum`/`kalan` become valid.
- `sifira_bolme`  out  1  divide-by-zero flag for the last result.

## Operation
- States: BOS (idle), HESAP (iterate), BITTI (result pulse).
- BOS:
  - `basla`=1 and `bolen`≠0: latch operands, clear the partial remainder, counter=WIDTH, go to HESAP.
  - `basla`=1 and `bolen`=0: go to BITTI with `bolum`=all ones, `kalan`=`bolunen`, `sifira_bolme`=1.
  - Otherwise stay in BOS.
- HESAP, each edge:
  - Shift {remainder, dividend} left by 1.
  - Trial-subtract the divisor from the WIDTH+1-bit remainder.
  - If the result is non-negative, keep the difference and shift in 1; otherwise restore and shift in 0.
  - Decrement the counter. On the edge where the counter reaches 0, write `bolum`/`kalan` and go to BITTI.
- BITTI: `hazir`=1 for exactly one cycle, then go to BOS unconditionally.
- `basla` is ignored in HESAP and BITTI. There is no queueing, and operand changes during those states have no effect.
- `bolum`, `kalan` and `sifira_bolme` hold their values until the next accepted start edge.
  - `sifira_bolme` clears on any accepted start with `bolen`≠0.
- Arithmetic is unsigned. The partial remainder is WIDTH+1 bits so the trial subtraction cannot overflow. `kalan` < `bolen` always holds for non-zero divisors.

## Timing
- Reset (`rst`=0, asynchronous): state=BOS; `bolum`=0, `kalan`=0, `mesgul`=0, `hazir`=0, `sifira_bolme`=0; counter=0. Reset asserted mid-division aborts it with no `hazir` pulse.
- Normal latency: start accepted at edge E0, HESAP occupies edges E1..E_WIDTH, `hazir` is high during the cycle after edge E_WIDTH.
  - For WIDTH=32, `hazir` is high in cycle 33 after the start edge.
- Divide-by-zero latency: `hazir` is high in the cycle immediately after the start edge.
- `mesgul`:
  - Normal: high from the cycle after E0 through the cycle before `hazir`.
  - Divide-by-zero: never asserts.
- `mesgul` and `hazir` are never high together.
- A new start is accepted earliest on the edge that ends the `hazir` cycle. At that edge the state is BITTI, so the start is ignored; the first acceptable edge is one cycle later, in BOS.
- Back-to-back throughput: one division per WIDTH+2 cycles.

## Structure
- Shared package `hesap_pkg`:
  - State enum (BOS, HESAP, BITTI).
  - Default width constant (32).
  - All-ones quotient constant for divide-by-zero.
- The multiplier migrates to the same width constant later.
- One natural sub-module, `bolme_adim`: purely combinational single iteration.
  - Inputs: WIDTH+1-bit remainder, dividend MSB, divisor.
  - Outputs: next remainder, quotient bit.
- `bolme` holds the FSM, counter and registers.

## Test plan
- 100 / 7 → after 33 cycles `hazir` pulses; `bolum`=14, `kalan`=2, `sifira_bolme`=0.
- 0xFFFFFFFF / 1 → `bolum`=0xFFFFFFFF, `kalan`=0; 0xFFFFFFFF / 0xFFFFFFFF → `bolum`=1, `kalan`=0.
- 5 / 9 → `bolum`=0, `kalan`=5; 0 / 3 → `bolum`=0, `kalan`=0.
- 1234 / 0 → `hazir` in the next cycle, `mesgul` never high; `bolum`=0xFFFFFFFF, `kalan`=1234, `sifira_bolme`=1.
  - Then 10 / 3 → `sifira_bolme`=0, `bolum`=3, `kalan`=1.
- Start 1000 / 10, pulse `basla` again with 50 / 5 at cycle 10, then drop `rst` at cycle 20:
  - No `hazir`; all outputs 0 immediately.
  - After release, 50 / 5 → `bolum`=10, `kalan`=0.
- Random 1000 unsigned operand pairs (non-zero divisor) checked against the reference model.
  - `bolunen` = `bolum`·`bolen` + `kalan`, and `kalan` < `bolen`.
  - Fixed latency holds, and `hazir` is exactly one cycle wide.
